gsim_result_buffer: RTL and testbench

GSIM_RESULT_BUFFER -- requirements
Module: gsim_result_buffer

---
 rtl/gsim_result_buffer.sv | 226 ++++++++++++++++++++++
 tb/tb_gsim_result_buffer.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gsim_result_buffer.sv
// -----------------------------------------------------------------------------
// gsim_result_buffer
//
// Purpose:
//   Collects one solution frame of DEPTH signed fixed-point elements from an
//   upstream solver, converts each element to a 16-bit signed integer as it is
//   written, then drains the frame in index order over a valid/ready port.
//   While capturing it tracks the largest |x_in| of the frame (saturating
//   |0x80000000| to 0x7FFFFFFF) and publishes it when the frame completes.
//
// Handshake (drain side): o_valid is asserted only while draining; an element
//   transfers on every rising clock edge where o_valid && o_ready are both 1.
//   o_data/o_idx are held stable while o_valid=1 and o_ready=0. The capture
//   side has no back-pressure: x_valid beats that arrive while a frame is
//   still draining are dropped and latch the sticky overrun flag. A beat that
//   coincides with acceptance of the last element starts the next frame.
//
// Ports:
//   clk        : single clock, all state on the rising edge
//   reset      : asynchronous active-high reset
//   x_valid    : solver result strobe
//   x_in       : signed Q(32-FRAC).FRAC element, natural order
//   o_valid    : drain data valid
//   o_ready    : downstream accept
//   o_data     : converted signed integer of the current element
//   o_idx      : index of the current element
//   frame_done : one-cycle pulse in the cycle after the last element is written
//   max_abs    : largest |x_in| of the last completed frame
//   overrun    : sticky, an element was dropped (cleared only by reset)
//
// Configuration:
//   GSIM_RESULT_ROUND_EN : when defined, conversion rounds half up and
//                          saturates to 0x7FFF on positive overflow; when not
//                          defined, conversion truncates toward minus infinity.
//
// DEPTH must be at least 2; FRAC must be in 1..16.
// -----------------------------------------------------------------------------
module gsim_result_buffer #(
    parameter int DEPTH = 16,
    parameter int FRAC  = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        x_valid,
    input  logic [31:0] x_in,
    output logic        o_valid,
    input  logic        o_ready,
    output logic [15:0] o_data,
    output logic [3:0]  o_idx,
    output logic        frame_done,
    output logic [31:0] max_abs,
    output logic        overrun
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic            frame_done_q, frame_done_d;
    logic [31:0]     max_abs_q, max_abs_d;
    logic [31:0]     run_max_q, run_max_d;
    logic            overrun_q, overrun_d;

    // Frame storage holds already-converted values; it is never reset because
    // a frame is only ever read after it has been completely rewritten.
    logic [15:0]     mem_q [DEPTH];

    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [15:0]     x_conv;
    logic [15:0]     x_hi;
    logic [31:0]     x_abs;
    logic [31:0]     x_max_new;

    // -------------------------------------------------------------------------
    // Element conversion
    // -------------------------------------------------------------------------
    assign x_hi = x_in[FRAC +: 16];

`ifdef GSIM_RESULT_ROUND_EN
    // Adding one half LSB and truncating equals adding the first discarded
    // bit to the truncated value; only 0x7FFF + 1 can overflow.
    always_comb begin
        if ((x_hi == 16'h7FFF) && x_in[FRAC-1]) begin
            x_conv = 16'h7FFF;
        end else begin
            x_conv = x_hi + {15'd0, x_in[FRAC-1]};
        end
    end
`else
    assign x_conv = x_hi;
`endif

    // |x_in| with the single unrepresentable magnitude clamped.
    always_comb begin
        if (x_in == 32'h8000_0000) begin
            x_abs = 32'h7FFF_FFFF;
        end else if (x_in[31]) begin
            x_abs = ~x_in + 32'd1;
        end else begin
            x_abs = x_in;
        end
    end

    assign x_max_new = (x_abs > run_max_q) ? x_abs : run_max_q;

    // -------------------------------------------------------------------------
    // FSM: next state and datapath controls
    // -------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        frame_done_d = 1'b0;
        max_abs_d    = max_abs_q;
        run_max_d    = run_max_q;
        overrun_d    = overrun_q;
        wr_en        = 1'b0;
        wr_addr      = wr_ptr_q;

        case (state_q)
            IDLE: begin
                if (x_valid) begin
                    wr_en     = 1'b1;
                    wr_addr   = '0;
                    wr_ptr_d  = AW'(1);
                    run_max_d = x_abs;
                    state_d   = FILL;
                end
            end

            FILL: begin
                if (x_valid) begin
                    wr_en     = 1'b1;
                    wr_addr   = wr_ptr_q;
                    run_max_d = x_max_new;
                    if (wr_ptr_q == LAST_PTR) begin
                        wr_ptr_d     = '0;
                        rd_ptr_d     = '0;
                        max_abs_d    = x_max_new;
                        frame_done_d = 1'b1;
                        state_d      = DRAIN;
                    end else begin
                        wr_ptr_d = wr_ptr_q + AW'(1);
                    end
                end
            end

            DRAIN: begin
                if (o_ready && (rd_ptr_q == LAST_PTR)) begin
                    rd_ptr_d = '0;
                    state_d  = IDLE;
                    // The buffer frees up on this edge, so a coinciding beat
                    // is the first element of the next frame, not a drop.
                    if (x_valid) begin
                        wr_en     = 1'b1;
                        wr_addr   = '0;
                        wr_ptr_d  = AW'(1);
                        run_max_d = x_abs;
                        state_d   = FILL;
                    end
                end else begin
                    if (o_ready) begin
                        rd_ptr_d = rd_ptr_q + AW'(1);
                    end
                    if (x_valid) begin
                        overrun_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            frame_done_q <= 1'b0;
            max_abs_q    <= '0;
            run_max_q    <= '0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            frame_done_q <= frame_done_d;
            max_abs_q    <= max_abs_d;
            run_max_q    <= run_max_d;
            overrun_q    <= overrun_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= x_conv;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign o_valid    = (state_q == DRAIN);
    // Forced to zero outside DRAIN so reset yields a clean zero output.
    assign o_data     = o_valid ? mem_q[rd_ptr_q] : 16'd0;
    assign o_idx      = 4'(rd_ptr_q);
    assign frame_done = frame_done_q;
    assign max_abs    = max_abs_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_gsim_result_buffer.sv
module tb_gsim_result_buffer;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        x_valid;
    logic [31:0] x_in;
    logic        o_valid;
    logic        o_ready;
    logic [15:0] o_data;
    logic [3:0]  o_idx;
    logic        frame_done;
    logic [31:0] max_abs;
    logic        overrun;

    gsim_result_buffer #(.DEPTH(DEPTH), .FRAC(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .x_valid    (x_valid),
        .x_in       (x_in),
        .o_valid    (o_valid),
        .o_ready    (o_ready),
        .o_data     (o_data),
        .o_idx      (o_idx),
        .frame_done (frame_done),
        .max_abs    (max_abs),
        .overrun    (overrun)
    );

    // ---------------------------------------------------------------- clock
    always #5 clk = ~clk;

    // ---------------------------------------------------------------- model
    int checks = 0;
    int errors = 0;
    int fd_count = 0;

    logic [15:0] exp_q[$];       // converted elements awaiting delivery
    logic [3:0]  exp_idx_q[$];
    logic [31:0] fill_q[$];      // raw elements of the frame being captured
    logic [15:0] obs_q[$];       // delivered elements, for scenario checks
    logic [31:0] exp_max;
    logic        exp_ovr;
    logic        exp_fd;

    function automatic logic [15:0] to_int(input logic [31:0] x);
        longint v;
        v = longint'($signed(x));
`ifdef GSIM_RESULT_ROUND_EN
        v = v + 64'sd32768;
        v = v >>> 16;
        if (v > 64'sd32767) v = 64'sd32767;
`else
        v = v >>> 16;
`endif
        return v[15:0];
    endfunction

    function automatic logic [31:0] abs_sat(input logic [31:0] x);
        longint v;
        v = longint'($signed(x));
        if (v < 0) v = -v;
        if (v > 64'sd2147483647) v = 64'sd2147483647;
        return v[31:0];
    endfunction

    task automatic model_reset();
        exp_q.delete();
        exp_idx_q.delete();
        fill_q.delete();
        exp_max = '0;
        exp_ovr = 1'b0;
        exp_fd  = 1'b0;
    endtask

    task automatic model_complete();
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < DEPTH; i++) begin
            exp_q.push_back(to_int(fill_q[i]));
            exp_idx_q.push_back(4'(i));
            if (abs_sat(fill_q[i]) > m) m = abs_sat(fill_q[i]);
        end
        exp_max = m;
        exp_fd  = 1'b1;
        fill_q.delete();
    endtask

    // ---------------------------------------------------------------- driver
    // Called at a falling edge: checks current outputs, drives inputs for the
    // next rising edge, advances the model across that edge.
    task automatic tick(input logic xv, input logic [31:0] xi, input logic rdy);
        logic ev;
        x_valid = xv;
        x_in    = xi;
        o_ready = rdy;
        ev = (exp_q.size() != 0);
        checks++;
        if (o_valid !== ev) begin
            errors++;
            $display("FAIL o_valid: got %b expected %b at %0t", o_valid, ev, $time);
        end
        if (ev) begin
            checks++;
            if (o_data !== exp_q[0]) begin
                errors++;
                $display("FAIL o_data: got %h expected %h at %0t", o_data, exp_q[0], $time);
            end
            checks++;
            if (o_idx !== exp_idx_q[0]) begin
                errors++;
                $display("FAIL o_idx: got %0d expected %0d at %0t", o_idx, exp_idx_q[0], $time);
            end
        end
        checks++;
        if (frame_done !== exp_fd) begin
            errors++;
            $display("FAIL frame_done: got %b expected %b at %0t", frame_done, exp_fd, $time);
        end
        checks++;
        if (overrun !== exp_ovr) begin
            errors++;
            $display("FAIL overrun: got %b expected %b at %0t", overrun, exp_ovr, $time);
        end
        checks++;
        if (max_abs !== exp_max) begin
            errors++;
            $display("FAIL max_abs: got %h expected %h at %0t", max_abs, exp_max, $time);
        end
        if (frame_done === 1'b1) fd_count++;

        exp_fd = 1'b0;
        if (ev && rdy) begin
            obs_q.push_back(o_data);
            void'(exp_q.pop_front());
            void'(exp_idx_q.pop_front());
        end
        // A beat is kept only if no undelivered element remains after this edge.
        if (xv) begin
            if (exp_q.size() == 0) begin
                fill_q.push_back(xi);
                if (fill_q.size() == DEPTH) model_complete();
            end else begin
                exp_ovr = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        x_valid = 1'b0;
        o_ready = 1'b0;
        reset   = 1'b1;
        model_reset();
        #1;
        checks++;
        if (o_valid !== 1'b0) begin errors++; $display("FAIL rst_o_valid: got %b expected 0", o_valid); end
        checks++;
        if (o_data !== 16'd0) begin errors++; $display("FAIL rst_o_data: got %h expected 0000", o_data); end
        checks++;
        if (o_idx !== 4'd0) begin errors++; $display("FAIL rst_o_idx: got %0d expected 0", o_idx); end
        checks++;
        if (frame_done !== 1'b0) begin errors++; $display("FAIL rst_frame_done: got %b expected 0", frame_done); end
        checks++;
        if (max_abs !== 32'd0) begin errors++; $display("FAIL rst_max_abs: got %h expected 0", max_abs); end
        checks++;
        if (overrun !== 1'b0) begin errors++; $display("FAIL rst_overrun: got %b expected 0", overrun); end
        // Beats offered while reset is held must be ignored.
        x_valid = 1'b1;
        x_in    = $urandom;
        @(negedge clk);
        x_in    = $urandom;
        @(negedge clk);
        reset   = 1'b0;
        x_valid = 1'b0;
    endtask

    // mode 0: ready held 1; mode 1: ready 1,0,0,1 repeating; mode 2: random
    task automatic drain(input int mode);
        int n;
        logic r;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            case (mode)
                0:       r = 1'b1;
                1:       r = ((n % 4) == 0) || ((n % 4) == 3);
                default: r = 1'($urandom_range(0, 1));
            endcase
            tick(1'b0, 32'd0, r);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
        tick(1'b0, 32'd0, 1'b1);
        tick(1'b0, 32'd0, 1'b1);
    endtask

    task automatic send_frame(input logic [31:0] vals[DEPTH], input bit gaps);
        int i;
        int n;
        i = 0;
        n = 0;
        while (i < DEPTH && n < 400) begin
            if (gaps && ($urandom_range(0, 3) == 0)) begin
                tick(1'b0, $urandom, 1'($urandom_range(0, 1)));
            end else begin
                tick(1'b1, vals[i], 1'($urandom_range(0, 1)));
                i++;
            end
            n++;
        end
    endtask

    // ---------------------------------------------------------------- tests
    task automatic test_reset();
        reset = 1'b1;
        x_valid = 1'b0;
        x_in = '0;
        o_ready = 1'b0;
        @(negedge clk);
        do_reset();
        for (int i = 0; i < 3; i++) tick(1'b0, 32'd0, 1'b1);
    endtask

    task automatic test_ramp();
        do_reset();
        obs_q.delete();
        fd_count = 0;
        for (int k = 0; k < DEPTH; k++) tick(1'b1, 32'(k) << 16, 1'b1);
        drain(0);
        checks++;
        if (fd_count != 1) begin errors++; $display("FAIL ramp_frame_done_count: got %0d expected 1", fd_count); end
        checks++;
        if (max_abs !== 32'h000F_0000) begin errors++; $display("FAIL ramp_max_abs: got %h expected 000f0000", max_abs); end
        checks++;
        if (obs_q.size() != DEPTH) begin
            errors++;
            $display("FAIL ramp_count: got %0d expected %0d", obs_q.size(), DEPTH);
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                checks++;
                if (obs_q[k] !== 16'(k)) begin
                    errors++;
                    $display("FAIL ramp_data[%0d]: got %h expected %h", k, obs_q[k], 16'(k));
                end
            end
        end
    endtask

    task automatic test_rounding();
        logic [31:0] vals[DEPTH];
        logic [15:0] e0, e1, e2;
        for (int i = 0; i < DEPTH; i++) vals[i] = $urandom;
        vals[0] = 32'h0001_8000;
        vals[1] = 32'hFFFE_8000;
        vals[2] = 32'h7FFF_C000;
`ifdef GSIM_RESULT_ROUND_EN
        e0 = 16'h0002; e1 = 16'hFFFF; e2 = 16'h7FFF;
`else
        e0 = 16'h0001; e1 = 16'hFFFE; e2 = 16'h7FFF;
`endif
        obs_q.delete();
        send_frame(vals, 1'b0);
        drain(0);
        checks++;
        if (obs_q.size() < 3) begin
            errors++;
            $display("FAIL round_count: got %0d expected %0d", obs_q.size(), DEPTH);
        end else begin
            checks++;
            if (obs_q[0] !== e0) begin errors++; $display("FAIL round_pos_half: got %h expected %h", obs_q[0], e0); end
            checks++;
            if (obs_q[1] !== e1) begin errors++; $display("FAIL round_neg_half: got %h expected %h", obs_q[1], e1); end
            checks++;
            if (obs_q[2] !== e2) begin errors++; $display("FAIL round_sat: got %h expected %h", obs_q[2], e2); end
        end
    endtask

    task automatic test_stall();
        logic [31:0] vals[DEPTH];
        for (int i = 0; i < DEPTH; i++) vals[i] = $urandom;
        obs_q.delete();
        send_frame(vals, 1'b1);
        drain(1);
        checks++;
        if (obs_q.size() != DEPTH) begin
            errors++;
            $display("FAIL stall_count: got %0d expected %0d", obs_q.size(), DEPTH);
        end
    endtask

    task automatic test_overrun();
        logic [31:0] vals[DEPTH];
        int n;
        do_reset();
        for (int i = 0; i < DEPTH; i++) vals[i] = $urandom;
        send_frame(vals, 1'b0);
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            tick((exp_q.size() > 1) && ($urandom_range(0, 1) == 1), $urandom, 1'($urandom_range(0, 1)));
            n++;
        end
        drain(0);
        checks++;
        if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_set: got %b expected 1", overrun); end
        for (int i = 0; i < DEPTH; i++) vals[i] = $urandom;
        send_frame(vals, 1'b1);
        drain(2);
        checks++;
        if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_sticky: got %b expected 1", overrun); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] vals[DEPTH];
        do_reset();
        for (int i = 0; i < 7; i++) tick(1'b1, $urandom, 1'b1);
        do_reset();
        fd_count = 0;
        obs_q.delete();
        for (int i = 0; i < DEPTH; i++) vals[i] = $urandom;
        send_frame(vals, 1'b0);
        drain(0);
        checks++;
        if (fd_count != 1) begin errors++; $display("FAIL reset_mid_frame_done: got %0d expected 1", fd_count); end
        checks++;
        if (obs_q.size() != DEPTH) begin errors++; $display("FAIL reset_mid_count: got %0d expected %0d", obs_q.size(), DEPTH); end
    endtask

    task automatic test_min_max();
        logic [31:0] vals[DEPTH];
        for (int i = 0; i < DEPTH; i++) vals[i] = 32'($urandom_range(0, 32'h00FF_FFFF));
        vals[$urandom_range(0, DEPTH - 1)] = 32'h8000_0000;
        send_frame(vals, 1'b1);
        drain(2);
        checks++;
        if (max_abs !== 32'h7FFF_FFFF) begin errors++; $display("FAIL min_max_abs: got %h expected 7fffffff", max_abs); end
    endtask

    task automatic test_back_to_back();
        int sent_b;
        int n;
        logic xv;
        do_reset();
        obs_q.delete();
        for (int i = 0; i < DEPTH; i++) tick(1'b1, $urandom, 1'b1);
        sent_b = 0;
        n = 0;
        while ((sent_b < DEPTH || exp_q.size() != 0) && n < 200) begin
            xv = (exp_q.size() <= 1) && (sent_b < DEPTH);
            tick(xv, $urandom, 1'b1);
            if (xv) sent_b++;
            n++;
        end
        drain(0);
        checks++;
        if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun: got %b expected 0", overrun); end
        checks++;
        if (obs_q.size() != 2 * DEPTH) begin errors++; $display("FAIL b2b_count: got %0d expected %0d", obs_q.size(), 2 * DEPTH); end
    endtask

    task automatic test_random();
        logic [31:0] vals[DEPTH];
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < DEPTH; i++) vals[i] = $urandom;
            send_frame(vals, 1'b1);
            drain(2);
        end
    endtask

    // ---------------------------------------------------------------- main
    initial begin
        test_reset();
        test_ramp();
        test_rounding();
        test_stall();
        test_overrun();
        test_reset_mid();
        test_min_max();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
